// File: rtl/tone_synth_core.sv
// tone_synth_core: registered note-code front end with an internal
// preset-load divider that drives the speaker square wave. Note changes
// take effect only at divider overflow (or immediately from rest), so a
// running period is never cut short. Also provides a rest mode, an
// octave-up mode, a run enable, and registered solfege digit/octave
// outputs for the 7-segment display.
module tone_synth_core #(
  parameter int CODE_W = 5,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CODE_W-1:0] code,
  input  logic              oct_up,
  output logic              spk,
  output logic              period_tick,
  output logic              note_valid,
  output logic [3:0]        note_digit,
  output logic [1:0]        note_oct
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam int               NUM_NOTES = 21;

  // Codes 1..21 are notes; 0 and anything above 21 mean rest.
  function automatic logic is_note_f(input logic [CODE_W-1:0] c);
    return (int'(c) >= 1) && (int'(c) <= NUM_NOTES);
  endfunction

  // Divider preset per note; the divider counts preset..MAX.
  function automatic logic [CNT_W-1:0] preset_f(input logic [CODE_W-1:0] c);
    case (int'(c))
      1:       return CNT_W'(137);
      2:       return CNT_W'(345);
      3:       return CNT_W'(531);
      4:       return CNT_W'(616);
      5:       return CNT_W'(773);
      6:       return CNT_W'(912);
      7:       return CNT_W'(1036);
      8:       return CNT_W'(1092);
      9:       return CNT_W'(1197);
      10:      return CNT_W'(1290);
      11:      return CNT_W'(1332);
      12:      return CNT_W'(1410);
      13:      return CNT_W'(1480);
      14:      return CNT_W'(1542);
      15:      return CNT_W'(1570);
      16:      return CNT_W'(1622);
      17:      return CNT_W'(1668);
      18:      return CNT_W'(1690);
      19:      return CNT_W'(1728);
      20:      return CNT_W'(1764);
      21:      return CNT_W'(1795);
      default: return '0;
    endcase
  endfunction

  // Halve a period for octave-up, never letting it collapse to zero.
  function automatic logic [CNT_W:0] sat_half_f(input logic [CNT_W:0] p);
    logic [CNT_W:0] h;
    h = p >> 1;
    return (h == '0) ? {{CNT_W{1'b0}}, 1'b1} : h;
  endfunction

  // Counter load value: 2^CNT_W minus the (possibly halved) period.
  function automatic logic [CNT_W-1:0] load_f(input logic [CODE_W-1:0] c,
                                              input logic              up);
    logic [CNT_W:0] full;
    logic [CNT_W:0] per;
    logic [CNT_W:0] ld;
    full = {1'b1, {CNT_W{1'b0}}};
    per  = full - {1'b0, preset_f(c)};
    if (up) per = sat_half_f(per);
    ld = full - per;
    return CNT_W'(ld);
  endfunction

  // Display decode: skip the unused slots so each octave holds digits 1..7.
  // Result is {oct[1:0], digit[3:0]}; rest shows 0/0.
  function automatic logic [5:0] disp_f(input logic [CODE_W-1:0] c);
    logic [4:0] c5;
    logic [4:0] t;
    c5 = c[4:0];
    if (!is_note_f(c)) return '0;
    if (c5 >= 5'd15)     t = c5 + 5'd2;
    else if (c5 >= 5'd8) t = c5 + 5'd1;
    else                 t = c5;
    return {t[4:3], 1'b0, t[2:0]};
  endfunction

  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic              spk_q,  spk_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [5:0]        disp_q, disp_d;

  logic playing;
  logic at_max;
  logic sample;

  assign playing = is_note_f(code_q);
  assign at_max  = (cnt_q == CNT_MAX);
  // Inputs are taken only at a period boundary or while resting.
  assign sample  = en && (!playing || at_max);

  // Next-state: sample a new note at the boundary, otherwise keep counting.
  always_comb begin
    cnt_d  = cnt_q;
    spk_d  = spk_q;
    code_d = code_q;
    disp_d = disp_q;
    if (en) begin
      if (sample) begin
        disp_d = disp_f(code);
        if (is_note_f(code)) begin
          code_d = code;
          cnt_d  = load_f(code, oct_up);
          // Coming out of rest the wave starts low; otherwise toggle.
          spk_d  = playing ? ~spk_q : 1'b0;
        end else begin
          code_d = '0;
          cnt_d  = '0;
          spk_d  = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset forces silence immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      spk_q  <= 1'b0;
      code_q <= '0;
      disp_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      spk_q  <= spk_d;
      code_q <= code_d;
      disp_q <= disp_d;
    end
  end

  assign spk         = spk_q;
  assign note_valid  = playing;
  assign period_tick = en && playing && at_max;
  assign note_digit  = disp_q[3:0];
  assign note_oct    = disp_q[5:4];

endmodule

// File: doc/tone_synth_core.md
Name: tone_synth_core

Overview:
- Parametrised successor to the combinational note-to-preset table.
- Registers the note code, looks up the divider preset, and runs the preset-load divider internally to produce the speaker square wave.
- Adds glitch-free note changes at period boundaries, an explicit rest/silence mode, an octave-up mode, a run enable, and registered digit/octave display outputs.
- Sits between the score ROM sequencer and the speaker pin / 7-segment display.

Parameters:
- CODE_W, 5, note code width; codes 0..21 are defined, all other codes are rest.
- CNT_W, 11, divider counter width; must be >= 11; MAX = 2^CNT_W - 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  run enable; low freezes all state.
- code  input  CODE_W  note code from the score sequencer.
- oct_up  input  1  raise the playing note one octave.
- spk  output  1  speaker square wave.
- period_tick  output  1  one-cycle pulse on each divider overflow.
- note_valid  output  1  high while a non-rest note is playing.
- note_digit  output  4  solfege digit 1..7; 0 on rest.
- note_oct  output  2  octave 0..2; 0 on rest.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; cnt=0; cur_code=0 (rest).
- Preset table, zero-extended to CNT_W, indexed by code 1..21:
  - 1..7: 137, 345, 531, 616, 773, 912, 1036
  - 8..14: 1092, 1197, 1290, 1332, 1410, 1480, 1542
  - 15..21: 1570, 1622, 1668, 1690, 1728, 1764, 1795
  - Code 0 or >21: rest.
- Period P = 2^CNT_W - preset. With oct_up=1: P' = max(P>>1, 1). Load value L = 2^CNT_W - P'.
- Divider, every clk with en=1 and cur_code not rest:
  - if cnt==MAX: period_tick=1, spk toggles, cnt<=L of the next note.
  - else: cnt<=cnt+1.
  - Overflow period = P' cycles; spk period = 2*P'.
- Note-change rule (glitch-free): code and oct_up are sampled only when cnt==MAX or when cur_code is rest.
  - The sampled value becomes cur_code and selects L in the same cycle.
  - A mid-period code change never truncates the current period.
- Rest to note: at the first en=1 cycle with a valid code, cur_code<=code, cnt<=L, spk stays 0, note_valid<=1. The first overflow follows P' cycles later.
- Note to rest: sampled at overflow. spk<=0 on that edge (overriding the toggle), cnt<=0, note_valid<=0, period_tick still pulses for that overflow.
- Rest: spk=0, cnt=0, period_tick=0.
- Display decode, registered, updated whenever cur_code updates:
  - t = code+2 if code>=15; t = code+1 if code>=8; else t = code (5-bit).
  - note_digit={1'b0,t[2:0]}, note_oct=t[4:3].
  - Rest gives digit 0, oct 0.
- en=0: cnt, spk, cur_code and display hold; period_tick=0; code is not sampled.
- Same code re-sampled: no reload glitch; behaves as continuous overflow.
- rst_n asserted mid-note: immediate silence, and all outputs return to their reset values asynchronously.
- Latency: code to cur_code/display is 1 cycle when resting, otherwise at the next overflow edge.

Test Plan:
- Reset, en=1, code=1 held: note_valid=1, digit=1, oct=0 after 1 cycle; period_tick every 1911 cycles; spk high for 1911 cycles, low for 1911.
- Code=21 playing, oct_up=0 then 1: period 253 cycles; after the next overflow the period becomes 126, spk period 252; digit=7, oct=2.
- Code changed 8->15 at 100 cycles into a 956-cycle period: the old period completes fully (956 cycles, no short pulse); then period 478; digit goes 1/oct1 to 1/oct2 at the overflow edge.
- Code=22 and code=0: spk=0, period_tick never pulses, note_valid=0, digit=0, oct=0. Then code=7: note starts the next cycle with period 1012.
- en=0 for 50 cycles mid-period on code=4 (period 1432): that period stretches to 1482 cycles; spk level unchanged during the pause.
- rst_n low asynchronously mid-cycle while playing code=10: spk, note_valid, digit and oct go 0 immediately (before the next clk edge); on release the block restarts from rest.
